// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score BCD path
package score_pkg;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W = 14;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} dec_state_t;
  typedef logic [3:0] bcd_t;
  typedef logic [SCORE_W-1:0] score_t;

  function automatic logic bcd_bad(input bcd_t d);
    return d > BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - combinational acc*10 + digit step for BCD accumulation
module bcd_mac10
  import score_pkg::*;
(
  input  score_t acc,
  input  bcd_t   digit,
  output score_t result
);
  // x10 as x8 + x2; wraps at SCORE_W, which only matters for illegal digits
  assign result = (acc << 3) + (acc << 1) + score_t'(digit);
endmodule

// File: rtl/score_bcd_decoder.sv
// rtl/score_bcd_decoder.sv - four-digit BCD to binary score converter
module score_bcd_decoder
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         thousands,
  input  logic [3:0]         hundreds,
  input  logic [3:0]         tens,
  input  logic [3:0]         ones,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] dig_sum,
  output logic               err,
  output logic               busy
);
  localparam logic [1:0] LAST_DIGIT = 2'(SCORE_DIGITS - 1);

  dec_state_t  state;
  logic [15:0] shreg;
  logic [1:0]  cnt;
  score_t      acc;
  score_t      mac_out;
  logic        err_pend;

  bcd_mac10 u_mac (
    .acc    (acc),
    .digit  (shreg[15:12]),
    .result (mac_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dig_sum   <= '0;
      err       <= 1'b0;
      err_pend  <= 1'b0;
      acc       <= '0;
      shreg     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg    <= {thousands, hundreds, tens, ones};
            acc      <= '0;
            cnt      <= '0;
            err_pend <= bcd_bad(thousands) | bcd_bad(hundreds) |
                        bcd_bad(tens) | bcd_bad(ones);
            state    <= S_CONV;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_CONV: begin
          acc   <= mac_out;
          shreg <= {shreg[11:0], 4'h0};
          cnt   <= cnt + 2'd1;
          if (cnt == LAST_DIGIT) begin
            // Any bad digit masks the (possibly wrapped) sum to zero
            dig_sum   <= err_pend ? '0 : mac_out;
            err       <= err_pend;
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
